// File: rtl/local_network_interface.sv
// Network interface between a core and a mesh router's local port.
// TX packetizes payload under credit flow control; RX buffers ejected flits and returns credits.
module local_network_interface #(
    parameter int TX_CREDITS = 4,
    parameter int RX_DEPTH   = 4,
    parameter int PKT_LEN    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] core_tx_dest_i,
    input  logic [15:0] core_tx_data_i,
    input  logic        core_tx_valid_i,
    output logic        core_tx_ready_o,
    output logic [15:0] ni_data_o,
    output logic        ni_valid_o,
    input  logic        ni_credit_i,
    input  logic [15:0] ni_data_i,
    input  logic        ni_valid_i,
    output logic        ni_credit_o,
    output logic [15:0] core_rx_data_o,
    output logic        core_rx_valid_o,
    output logic        core_rx_head_o,
    input  logic        core_rx_ready_i,
    output logic        tx_credit_err_o,
    output logic        rx_overflow_o
);
    localparam int CW = $clog2(TX_CREDITS + 1);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int BW = $clog2(PKT_LEN);

    typedef enum logic [1:0] {IDLE, HEADER, BODY} tx_state_t;

    tx_state_t       state, state_nxt;
    logic [15:0]     dest_q;
    logic [BW-1:0]   body_cnt;
    logic [CW-1:0]   tx_credit;
    logic            has_credit;
    logic            send;
    logic [15:0]     send_data;

    assign has_credit = (tx_credit != '0);

    always_comb begin
        state_nxt       = state;
        core_tx_ready_o = 1'b0;
        send            = 1'b0;
        send_data       = dest_q;
        case (state)
            IDLE: if (core_tx_valid_i) state_nxt = HEADER;
            HEADER: if (has_credit) begin
                send      = 1'b1;
                state_nxt = BODY;
            end
            BODY: if (core_tx_valid_i && has_credit) begin
                core_tx_ready_o = 1'b1;
                send            = 1'b1;
                send_data       = core_tx_data_i;
                if (body_cnt == BW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            dest_q          <= '0;
            body_cnt        <= '0;
            tx_credit       <= CW'(TX_CREDITS);
            tx_credit_err_o <= 1'b0;
            ni_valid_o      <= 1'b0;
            ni_data_o       <= '0;
        end else begin
            state      <= state_nxt;
            ni_valid_o <= send;
            if (send) ni_data_o <= send_data;
            if (state == IDLE && core_tx_valid_i) dest_q <= core_tx_dest_i;
            if (send) body_cnt <= (state == HEADER) ? BW'(PKT_LEN - 1) : body_cnt - BW'(1);
            // A return arriving with the counter already full is a protocol error; hold.
            case ({send, ni_credit_i})
                2'b10: tx_credit <= tx_credit - CW'(1);
                2'b01: begin
                    if (tx_credit == CW'(TX_CREDITS)) tx_credit_err_o <= 1'b1;
                    else                              tx_credit <= tx_credit + CW'(1);
                end
                default: ;
            endcase
        end
    end

    logic [15:0]   mem [RX_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [BW-1:0] rx_cnt;
    logic          empty, full, rd_en, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = core_rx_ready_i && !empty;
    assign wr_en = ni_valid_i && (!full || rd_en);

    assign core_rx_data_o  = mem[rd_ptr[AW-1:0]];
    assign core_rx_valid_o = !empty;
    assign core_rx_head_o  = !empty && (rx_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rx_cnt        <= '0;
            ni_credit_o   <= 1'b0;
            rx_overflow_o <= 1'b0;
        end else begin
            ni_credit_o <= rd_en;
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= ni_data_i;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                rx_cnt <= (rx_cnt == BW'(PKT_LEN - 1)) ? '0 : rx_cnt + BW'(1);
            end
            if (ni_valid_i && full && !rd_en) rx_overflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_local_network_interface.sv
// Directed bench for local_network_interface: TX packetizing/credits, RX FIFO/credits, reset.
module tb_local_network_interface;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] core_tx_dest_i, core_tx_data_i, ni_data_i;
    logic        core_tx_valid_i, ni_credit_i, ni_valid_i, core_rx_ready_i;
    logic        core_tx_ready_o, ni_valid_o, ni_credit_o, core_rx_valid_o, core_rx_head_o;
    logic        tx_credit_err_o, rx_overflow_o;
    logic [15:0] ni_data_o, core_rx_data_o;

    int total = 0;
    int bad   = 0;
    int cnt;
    logic [15:0] last;

    local_network_interface dut (
        .clk(clk), .reset(reset),
        .core_tx_dest_i(core_tx_dest_i), .core_tx_data_i(core_tx_data_i),
        .core_tx_valid_i(core_tx_valid_i), .core_tx_ready_o(core_tx_ready_o),
        .ni_data_o(ni_data_o), .ni_valid_o(ni_valid_o), .ni_credit_i(ni_credit_i),
        .ni_data_i(ni_data_i), .ni_valid_i(ni_valid_i), .ni_credit_o(ni_credit_o),
        .core_rx_data_o(core_rx_data_o), .core_rx_valid_o(core_rx_valid_o),
        .core_rx_head_o(core_rx_head_o), .core_rx_ready_i(core_rx_ready_i),
        .tx_credit_err_o(tx_credit_err_o), .rx_overflow_o(rx_overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        core_tx_dest_i = '0; core_tx_data_i = '0; core_tx_valid_i = 0;
        ni_credit_i = 0; ni_data_i = '0; ni_valid_i = 0; core_rx_ready_i = 0;
        reset = 1;
        step(); step();
        reset = 0;
    endtask

    task automatic rx_push(input logic [15:0] d);
        ni_valid_i = 1; ni_data_i = d;
        step();
        ni_valid_i = 0;
    endtask

    initial begin
        do_reset();
        // reset state
        chk("rst_ni_valid", ni_valid_o, 0);
        chk("rst_ni_data", ni_data_o, 0);
        chk("rst_tx_ready", core_tx_ready_o, 0);
        chk("rst_rx_valid", core_rx_valid_o, 0);
        chk("rst_rx_head", core_rx_head_o, 0);
        chk("rst_ni_credit", ni_credit_o, 0);
        chk("rst_errs", {tx_credit_err_o, rx_overflow_o}, 0);
        chk("rst_credit", dut.tx_credit, 4);

        // single packet 0102, A1..A3
        core_tx_valid_i = 1; core_tx_dest_i = 16'h0102; core_tx_data_i = 16'h00A1;
        chk("p1_idle_ready", core_tx_ready_o, 0);
        step();
        chk("p1_hdr_ready", core_tx_ready_o, 0);
        chk("p1_hdr_novalid", ni_valid_o, 0);
        step();
        chk("p1_h_valid", ni_valid_o, 1);
        chk("p1_h_data", ni_data_o, 16'h0102);
        chk("p1_b1_ready", core_tx_ready_o, 1);
        step();
        core_tx_data_i = 16'h00A2;
        chk("p1_a1", {ni_valid_o, ni_data_o}, {1'b1, 16'h00A1});
        chk("p1_b2_ready", core_tx_ready_o, 1);
        step();
        core_tx_data_i = 16'h00A3;
        chk("p1_a2", {ni_valid_o, ni_data_o}, {1'b1, 16'h00A2});
        chk("p1_b3_ready", core_tx_ready_o, 1);
        step();
        core_tx_valid_i = 0;
        chk("p1_a3", {ni_valid_o, ni_data_o}, {1'b1, 16'h00A3});
        chk("p1_end_ready", core_tx_ready_o, 0);
        chk("p1_credit0", dut.tx_credit, 0);
        step();
        chk("p1_pulse_end", ni_valid_o, 0);
        chk("p1_data_hold", ni_data_o, 16'h00A3);

        // credit overflow error
        do_reset();
        ni_credit_i = 1;
        step();
        ni_credit_i = 0;
        chk("cerr_flag", tx_credit_err_o, 1);
        chk("cerr_hold", dut.tx_credit, 4);

        // credit stall with two packets offered
        do_reset();
        core_tx_valid_i = 1; core_tx_dest_i = 16'h0203; core_tx_data_i = 16'h00B0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ni_valid_o) cnt++;
        end
        chk("stall_flits", cnt, 4);
        chk("stall_ready", core_tx_ready_o, 0);
        chk("stall_credit", dut.tx_credit, 0);
        ni_credit_i = 1;
        step();
        ni_credit_i = 0;
        cnt = 0; last = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ni_valid_o) begin cnt++; last = ni_data_o; end
        end
        chk("ret1_flits", cnt, 1);
        chk("ret1_hdr2", last, 16'h0203);
        chk("ret1_ready", core_tx_ready_o, 0);

        // simultaneous send and credit return at credit 1
        ni_credit_i = 1;
        step();
        chk("sim_pre_ready", core_tx_ready_o, 1);
        step();
        ni_credit_i = 0;
        chk("sim_credit1", dut.tx_credit, 1);
        chk("sim_nostall", core_tx_ready_o, 1);
        chk("sim_sent", ni_valid_o, 1);
        step();
        chk("sim_next_sent", ni_valid_o, 1);
        chk("sim_after_ready", core_tx_ready_o, 0);
        core_tx_valid_i = 0;

        // RX: header + 3 body, then pop all
        do_reset();
        rx_push(16'h1100); rx_push(16'h1101); rx_push(16'h1102); rx_push(16'h1103);
        chk("rx_valid", core_rx_valid_o, 1);
        chk("rx_head_h", core_rx_head_o, 1);
        chk("rx_data_h", core_rx_data_o, 16'h1100);
        chk("rx_no_credit", ni_credit_o, 0);
        core_rx_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            chk("rx_pop_data", core_rx_data_o, 32'h1100 + i);
            chk("rx_pop_head", core_rx_head_o, (i == 0) ? 1 : 0);
            step();
            chk("rx_credit_pulse", ni_credit_o, 1);
        end
        core_rx_ready_i = 0;
        chk("rx_empty", core_rx_valid_o, 0);
        step();
        chk("rx_credit_end", ni_credit_o, 0);

        // RX overflow: 5th flit dropped
        rx_push(16'h2000); rx_push(16'h2001); rx_push(16'h2002); rx_push(16'h2003);
        chk("ovf_clear", rx_overflow_o, 0);
        rx_push(16'h2004);
        chk("ovf_set", rx_overflow_o, 1);
        core_rx_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_data", core_rx_data_o, 32'h2000 + i);
            step();
        end
        core_rx_ready_i = 0;
        chk("ovf_dropped", core_rx_valid_o, 0);

        // RX full with simultaneous pop: accepted, no error
        do_reset();
        rx_push(16'h3000); rx_push(16'h3001); rx_push(16'h3002); rx_push(16'h3003);
        ni_valid_i = 1; ni_data_i = 16'h3004; core_rx_ready_i = 1;
        step();
        ni_valid_i = 0;
        chk("fullrw_noerr", rx_overflow_o, 0);
        for (int i = 1; i < 5; i++) begin
            chk("fullrw_data", core_rx_data_o, 32'h3000 + i);
            step();
        end
        core_rx_ready_i = 0;
        chk("fullrw_empty", core_rx_valid_o, 0);

        // reset mid-BODY after header and one body flit
        do_reset();
        core_tx_valid_i = 1; core_tx_dest_i = 16'h0600; core_tx_data_i = 16'h6001;
        step(); step(); step();
        chk("mid_sent", {ni_valid_o, ni_data_o}, {1'b1, 16'h6001});
        chk("mid_credit2", dut.tx_credit, 2);
        #1 reset = 1;
        #1;
        chk("mid_async_valid", ni_valid_o, 0);
        chk("mid_async_data", ni_data_o, 0);
        chk("mid_async_ready", core_tx_ready_o, 0);
        chk("mid_credit4", dut.tx_credit, 4);
        reset = 0;
        core_tx_dest_i = 16'h0700; core_tx_data_i = 16'h7001;
        chk("mid_idle_ready", core_tx_ready_o, 0);
        step(); step();
        chk("mid_new_hdr", {ni_valid_o, ni_data_o}, {1'b1, 16'h0700});
        core_tx_valid_i = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/local_network_interface.md
Name: local_network_interface

Overview:
- Network interface (NI) that sits between a processing core and the local (L) port of one mesh router. It is the far end of the router's local-port credit protocol.
- TX path: packetizes core payload into header plus body flits and drives them into the router's local input buffer under credit-based flow control.
- RX path: buffers flits the router ejects on its local output, presents them to the core, and returns one credit per flit consumed.

Parameters:
- TX_CREDITS, 4, depth of the router's local input buffer; TX credit counter reset value.
- RX_DEPTH, 4, depth of the NI receive FIFO; must equal the router's local-port credit-counter reset value.
- PKT_LEN, 4, flits per packet including header (min 2).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- core_tx_dest_i  input  16  destination YX address, sampled at packet start
- core_tx_data_i  input  16  payload flit
- core_tx_valid_i  input  1  payload flit valid
- core_tx_ready_o  output  1  payload flit accepted this cycle
- ni_data_o  output  16  flit to router local input (router l_data_i)
- ni_valid_o  output  1  flit valid / buffer write (router l_valid_i)
- ni_credit_i  input  1  credit return from router (router l_credit_o)
- ni_data_i  input  16  flit from router local output (router l_data_o)
- ni_valid_i  input  1  flit valid from router (router l_valid_o)
- ni_credit_o  output  1  credit to router (router l_credit_i)
- core_rx_data_o  output  16  head-of-FIFO flit
- core_rx_valid_o  output  1  RX FIFO non-empty
- core_rx_head_o  output  1  current core_rx_data_o is a header flit
- core_rx_ready_i  input  1  core pops flit
- tx_credit_err_o  output  1  sticky: credit received while counter at TX_CREDITS
- rx_overflow_o  output  1  sticky: flit arrived while RX FIFO full

Behaviour:
- Reset (async, active-high): all outputs 0; TX credit counter = TX_CREDITS; RX FIFO empty; TX FSM = IDLE; RX flit counter = 0.
- TX credit counter:
  - Decrement on each flit sent; increment on ni_credit_i.
  - Both in the same cycle: no change.
  - Increment at TX_CREDITS: counter holds and tx_credit_err_o is set.
  - A flit may be sent only when credit > 0.
- TX FSM, states IDLE, HEADER, BODY:
  - IDLE: on core_tx_valid_i, latch core_tx_dest_i, go to HEADER. Payload is not consumed in IDLE.
  - HEADER: when credit > 0, register ni_data_o = latched dest and ni_valid_o = 1 for exactly one cycle; load body count = PKT_LEN-1; go to BODY.
  - BODY: when core_tx_valid_i and credit > 0, assert core_tx_ready_o combinationally, register ni_data_o = core_tx_data_i and ni_valid_o = 1 next cycle, decrement body count. At count 0 after the last body flit, go to IDLE.
  - core_tx_ready_o is 0 outside BODY or when credit = 0.
- TX latency: a flit accepted in cycle N appears on ni_valid_o/ni_data_o in cycle N+1. ni_valid_o is a single-cycle pulse per flit; ni_data_o holds its value when not valid.
- Back-to-back: up to one flit per cycle while credit allows. Credit returned in cycle N is usable in cycle N+1.
- RX FIFO:
  - Write on ni_valid_i; read on core_rx_ready_i && core_rx_valid_i. core_rx_data_o is show-ahead.
  - Pointers are log2(RX_DEPTH) bits with an extra wrap bit distinguishing full from empty.
  - Simultaneous read and write while full: both allowed.
  - Write while full and no read: flit dropped, rx_overflow_o set.
- RX header tracking: flit counter mod PKT_LEN advances on each pop. core_rx_head_o = 1 when counter = 0.
- ni_credit_o: registered one-cycle pulse in the cycle after each pop; one pulse per popped flit.
- Reset mid-packet: TX returns to IDLE, partial packet is abandoned, credit is restored to TX_CREDITS. The router must be reset together with the NI.

Test Plan:
- Single packet, dest 16'h0102, payload A1,A2,A3, credits 4: ni_valid_o pulses 4 consecutive cycles with 0102,A1,A2,A3; credit falls to 0; core_tx_ready_o high 3 cycles.
- Credit stall: credits 4, no returns, two packets offered: exactly 4 flits sent, core_tx_ready_o stays 0. One ni_credit_i pulse gives exactly one further flit (header 2) the next cycle.
- Simultaneous ni_credit_i and send at credit 1: counter stays 1; the next flit goes out without stall.
- RX: 4 flits H,B1,B2,B3 enter with core_rx_ready_i=0: core_rx_valid_o=1 and core_rx_head_o=1 on H. Popping all 4 gives 4 ni_credit_o pulses, each one cycle after its pop; core_rx_head_o is high only for H.
- RX overflow: 5th flit with FIFO full and no pop: flit dropped, rx_overflow_o=1; a pop in the same cycle instead accepts it with no error.
- Reset asserted in BODY after 2 flits: outputs 0 immediately (async); after release, credit = 4, FSM IDLE, next packet starts with a header.
